// File: rtl/serial_parity_checker.sv
// serial_parity_checker
//   Receive end of the XOR parity link. Deserializes a frame of DATA_W data bits
//   (LSB first) followed by one parity bit, reduces it with a running XOR and
//   presents the word plus a parity-error flag through a valid/ready output register.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   in_valid     in_bit/in_sof valid this cycle (a "beat")
//   in_bit       serial bit
//   in_sof       marks in_bit as data bit 0 of a new frame
//   out_valid    out_data/out_par_err hold a frame result
//   out_ready    consumer accepts the result when out_valid & out_ready
//   out_data     deserialized word, bit i = i-th data bit received
//   out_par_err  1 = parity mismatch for out_data
//   busy         1 while a frame is being received (state != IDLE)
//   overrun      1-cycle pulse: completed frame dropped because the output was full
//   frame_abort  1-cycle pulse: in_sof arrived mid-frame, partial frame discarded
module serial_parity_checker #(
  parameter int DATA_W     = 8,
  parameter bit ODD_PARITY = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic              in_bit,
  input  logic              in_sof,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_par_err,
  output logic              busy,
  output logic              overrun,
  output logic              frame_abort
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              acc_q, acc_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              abort_q, abort_d;

  logic              done;
  logic              done_err;

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              err_q, err_d;
  logic              overrun_q, overrun_d;

  // Receive FSM: deserializer, running XOR and bit counter
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    shreg_d  = shreg_q;
    abort_d  = 1'b0;
    done     = 1'b0;
    done_err = acc_q ^ in_bit ^ ODD_PARITY;

    if (in_valid) begin
      if (in_sof) begin
        // A start-of-frame always restarts; it is only an abort if a frame was open.
        abort_d    = (state_q != IDLE);
        state_d    = DATA;
        cnt_d      = CNT_W'(1);
        acc_d      = in_bit;
        shreg_d    = '0;
        shreg_d[0] = in_bit;
      end else begin
        case (state_q)
          IDLE: begin
            // stray bit outside a frame is ignored
          end
          DATA: begin
            shreg_d[cnt_q] = in_bit;
            acc_d          = acc_q ^ in_bit;
            // Counter saturates at the last index instead of wrapping.
            if (cnt_q == LAST_IDX) state_d = PARITY;
            else                   cnt_d   = cnt_q + CNT_W'(1);
          end
          PARITY: begin
            done    = 1'b1;
            state_d = IDLE;
            cnt_d   = '0;
            acc_d   = 1'b0;
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= 1'b0;
      shreg_q <= '0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      shreg_q <= shreg_d;
      abort_q <= abort_d;
    end
  end

  // Output register: holds one result; a completion while full and not being
  // drained is dropped and flagged as overrun.
  always_comb begin
    valid_d   = valid_q;
    data_d    = data_q;
    err_d     = err_q;
    overrun_d = 1'b0;

    if (done) begin
      if (!valid_q || out_ready) begin
        valid_d = 1'b1;
        data_d  = shreg_q;
        err_d   = done_err;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      data_q    <= '0;
      err_q     <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      data_q    <= data_d;
      err_q     <= err_d;
      overrun_q <= overrun_d;
    end
  end

  assign out_valid   = valid_q;
  assign out_data    = data_q;
  assign out_par_err = err_q;
  assign busy        = (state_q != IDLE);
  assign overrun     = overrun_q;
  assign frame_abort = abort_q;

endmodule

// File: tb/tb_serial_parity_checker.sv
// Testbench for serial_parity_checker: an even-parity and an odd-parity instance
// share one stimulus stream; a frame-level reference model predicts all outputs.
module tb_serial_parity_checker;

  localparam int DW = 8;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_bit;
  logic          in_sof;
  logic          out_ready;

  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_par_err;
  logic          busy;
  logic          overrun;
  logic          frame_abort;

  logic          o_valid;
  logic [DW-1:0] o_data;
  logic          o_par_err;
  logic          o_busy;
  logic          o_overrun;
  logic          o_abort;

  int errors = 0;
  int checks = 0;

  serial_parity_checker #(.DATA_W(DW), .ODD_PARITY(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_bit(in_bit), .in_sof(in_sof),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_par_err(out_par_err), .busy(busy), .overrun(overrun), .frame_abort(frame_abort)
  );

  serial_parity_checker #(.DATA_W(DW), .ODD_PARITY(1'b1)) dut_odd (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_bit(in_bit), .in_sof(in_sof),
    .out_valid(o_valid), .out_ready(out_ready), .out_data(o_data),
    .out_par_err(o_par_err), .busy(o_busy), .overrun(o_overrun), .frame_abort(o_abort)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state: bits of the open frame, plus the output register contents.
  bit            fq[$];
  bit            m_valid;
  logic [DW-1:0] m_data;
  bit            m_err;
  bit            m_err_o;
  bit            m_over;
  bit            m_abort;
  bit            m_busy;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    fq.delete();
    m_valid = 0; m_data = '0; m_err = 0; m_err_o = 0;
    m_over = 0; m_abort = 0; m_busy = 0;
  endtask

  task automatic compare_all(input string tag);
    chk({tag, ".out_valid"},    {31'd0, out_valid},   {31'd0, m_valid});
    chk({tag, ".out_data"},     {24'd0, out_data},    {24'd0, m_data});
    chk({tag, ".out_par_err"},  {31'd0, out_par_err}, {31'd0, m_err});
    chk({tag, ".busy"},         {31'd0, busy},        {31'd0, m_busy});
    chk({tag, ".overrun"},      {31'd0, overrun},     {31'd0, m_over});
    chk({tag, ".frame_abort"},  {31'd0, frame_abort}, {31'd0, m_abort});
    chk({tag, ".odd_par_err"},  {31'd0, o_par_err},   {31'd0, m_err_o});
    chk({tag, ".odd_data"},     {24'd0, o_data},      {24'd0, m_data});
  endtask

  // Advance one clock: update the model from the inputs applied this cycle,
  // then compare all outputs just after the edge.
  task automatic step(input string tag);
    bit            done = 0;
    bit            n_over = 0;
    bit            n_abort = 0;
    int            ones = 0;
    logic [DW-1:0] d = '0;
    if (in_valid) begin
      if (in_sof) begin
        if (fq.size() != 0) n_abort = 1;
        fq.delete();
        fq.push_back(in_bit);
      end else if (fq.size() != 0) begin
        fq.push_back(in_bit);
        if (fq.size() == DW + 1) begin
          done = 1;
          for (int i = 0; i < DW; i++) d[i] = fq[i];
          foreach (fq[i]) ones += int'(fq[i]);
          fq.delete();
        end
      end
    end
    if (done) begin
      if (!m_valid || out_ready) begin
        m_valid = 1;
        m_data  = d;
        m_err   = (ones % 2) != 0;
        m_err_o = (ones % 2) == 0;
      end else begin
        n_over = 1;
      end
    end else if (m_valid && out_ready) begin
      m_valid = 0;
    end
    m_over  = n_over;
    m_abort = n_abort;
    m_busy  = fq.size() != 0;
    @(posedge clk);
    #1;
    compare_all(tag);
  endtask

  task automatic idle(input string tag);
    in_valid = 0; in_sof = 0; in_bit = 0;
    step(tag);
  endtask

  // Send DW data bits LSB first then the parity bit; optional gap cycles carry
  // junk on in_sof/in_bit with in_valid low.
  task automatic send_frame(input logic [DW-1:0] d, input logic p, input bit gaps, input string tag);
    for (int i = 0; i < DW; i++) begin
      in_valid = 1; in_sof = (i == 0); in_bit = d[i];
      step(tag);
      if (gaps) begin
        in_valid = 0; in_sof = 1; in_bit = ~d[i];
        step(tag);
      end
    end
    in_valid = 1; in_sof = 0; in_bit = p;
    step(tag);
    in_valid = 0; in_sof = 0;
  endtask

  typedef struct {
    logic [DW-1:0] d;
    logic          p;
    logic [DW-1:0] exp_d;
    logic          exp_e;
    logic          exp_eo;
  } vec_t;

  vec_t tbl[8];

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = '{8'hA5, 1'b0, 8'hA5, 1'b0, 1'b1};
    tbl[1] = '{8'hA5, 1'b1, 8'hA5, 1'b1, 1'b0};
    tbl[2] = '{8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
    tbl[3] = '{8'h00, 1'b0, 8'h00, 1'b0, 1'b1};
    tbl[4] = '{8'hFF, 1'b0, 8'hFF, 1'b0, 1'b1};
    tbl[5] = '{8'h3C, 1'b0, 8'h3C, 1'b0, 1'b1};
    tbl[6] = '{8'h01, 1'b1, 8'h01, 1'b0, 1'b1};
    tbl[7] = '{8'h80, 1'b0, 8'h80, 1'b1, 1'b0};

    rst_n = 0; in_valid = 0; in_bit = 0; in_sof = 0; out_ready = 1;
    model_reset();
    #2;
    compare_all("reset");
    @(negedge clk);
    rst_n = 1;
    idle("post_reset");

    // Table: single frames with the consumer always ready.
    foreach (tbl[k]) begin
      out_ready = 1;
      send_frame(tbl[k].d, tbl[k].p, 0, "tbl");
      chk("tbl.valid",   {31'd0, out_valid},   32'd1);
      chk("tbl.data",    {24'd0, out_data},    {24'd0, tbl[k].exp_d});
      chk("tbl.err",     {31'd0, out_par_err}, {31'd0, tbl[k].exp_e});
      chk("tbl.err_odd", {31'd0, o_par_err},   {31'd0, tbl[k].exp_eo});
      idle("tbl_drain");
      chk("tbl.drained", {31'd0, out_valid},   32'd0);
    end

    // Back-to-back frames, sof right after the parity beat.
    out_ready = 1;
    send_frame(8'h5A, 1'b0, 0, "b2b");
    chk("b2b.first", {24'd0, out_data}, 32'h5A);
    send_frame(8'hC3, 1'b1, 0, "b2b");
    chk("b2b.second",     {24'd0, out_data},    32'hC3);
    chk("b2b.second_err", {31'd0, out_par_err}, 32'd1);
    idle("b2b_drain");

    // Overrun: output full and stalled, second frame dropped.
    out_ready = 0;
    send_frame(8'h11, 1'b0, 0, "ovr");
    send_frame(8'h22, 1'b0, 0, "ovr");
    chk("ovr.pulse", {31'd0, overrun},  32'd1);
    chk("ovr.kept",  {24'd0, out_data}, 32'h11);
    idle("ovr_hold");
    chk("ovr.once",  {31'd0, overrun},  32'd0);
    chk("ovr.still", {24'd0, out_data}, 32'h11);
    out_ready = 1;
    idle("ovr_accept");
    chk("ovr.accepted", {31'd0, out_valid}, 32'd0);

    // Abort: sof after 4 data bits, then a full frame with idle gaps.
    for (int i = 0; i < 4; i++) begin
      in_valid = 1; in_sof = (i == 0); in_bit = 1'(i);
      step("abort_part");
    end
    in_valid = 1; in_sof = 1; in_bit = 1'b0;
    step("abort_sof");
    chk("abort.pulse", {31'd0, frame_abort}, 32'd1);
    in_valid = 0; in_sof = 0;
    step("abort_gap");
    chk("abort.once", {31'd0, frame_abort}, 32'd0);
    // 0x3C bit0 already sent (0); finish the frame with gaps between beats.
    for (int i = 1; i < DW; i++) begin
      in_valid = 1; in_sof = 0; in_bit = 1'((8'h3C >> i) & 1);
      step("abort_frame");
      in_valid = 0; in_sof = 1; in_bit = 1'b1;
      step("abort_frame_gap");
    end
    in_valid = 1; in_sof = 0; in_bit = 1'b0;
    step("abort_par");
    chk("abort.data", {24'd0, out_data},    32'h3C);
    chk("abort.err",  {31'd0, out_par_err}, 32'd0);
    idle("abort_drain");
    send_frame(8'h96, 1'b1, 1, "gaps");
    idle("gaps_drain");

    // Async reset mid-frame with a pending result.
    out_ready = 0;
    send_frame(8'h42, 1'b0, 0, "rst_pre");
    for (int i = 0; i < 4; i++) begin
      in_valid = 1; in_sof = (i == 0); in_bit = 1'b1;
      step("rst_part");
    end
    chk("rst.pending", {31'd0, out_valid}, 32'd1);
    in_valid = 0; in_sof = 0;
    #1 rst_n = 0;
    #1;
    model_reset();
    compare_all("async_rst");
    @(negedge clk);
    rst_n = 1;
    out_ready = 1;
    idle("rst_release");
    send_frame(8'hFF, 1'b0, 0, "rst_post");
    chk("rst.post_data", {24'd0, out_data},    32'hFF);
    chk("rst.post_err",  {31'd0, out_par_err}, 32'd0);
    idle("rst_drain");

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      in_valid  = ($urandom % 4) != 0;
      in_sof    = (fq.size() != 0) ? (($urandom % 24) == 0) : (($urandom % 3) == 0);
      in_bit    = 1'($urandom % 2);
      out_ready = 1'($urandom % 2);
      step("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
